// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes one RV32I OP/OP-IMM instruction, drives ALU32 from a 32x32 regfile and writes the result back
module alu_issue_stage #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 6,
  parameter int NREGS   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_instr_valid,
  output logic               o_instr_ready,
  input  logic [31:0]        i_instr,
  output logic [WIDTH-1:0]   o_alu_in1,
  output logic [WIDTH-1:0]   o_alu_in2,
  output logic [OPWIDTH-1:0] o_alu_op,
  input  logic [WIDTH-1:0]   i_alu_result,
  output logic               o_res_valid,
  output logic               o_res_illegal,
  output logic [4:0]         o_res_rd,
  output logic [WIDTH-1:0]   o_res_data,
  input  logic [4:0]         i_dbg_addr,
  output logic [WIDTH-1:0]   o_dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_illegal;
  logic [4:0]       r_rd;
  logic [6:0]       w_opc, w_f7;
  logic [2:0]       w_f3;
  logic [4:0]       w_rs1, w_rs2;
  logic [WIDTH-1:0] w_imm, w_shamt, w_in1, w_in2;
  logic [OPWIDTH-1:0] w_op;
  logic             w_legal, w_accept;
  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_imm    = {{(WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign w_shamt  = WIDTH'(i_instr[24:20]);
  assign w_accept = r_state == IDLE && i_instr_valid;
  assign o_instr_ready = r_state == IDLE;
  assign o_dbg_data    = r_regs[i_dbg_addr];
  always_comb begin
    w_legal = 1'b0;
    w_op    = OPWIDTH'(4);
    w_in1   = r_regs[w_rs1];
    w_in2   = w_imm;
    if (w_opc == 7'b0010011) begin
      w_legal = 1'b1;
      case (w_f3)
        3'b000: w_op = OPWIDTH'(4);
        3'b010: w_op = OPWIDTH'(5);
        3'b011: w_op = OPWIDTH'(6);
        3'b100: w_op = OPWIDTH'(7);
        3'b110: w_op = OPWIDTH'(8);
        3'b111: w_op = OPWIDTH'(9);
        3'b001: begin
          w_op    = OPWIDTH'(10);
          w_in2   = w_shamt;
          w_legal = w_f7 == 7'b0000000;
        end
        default: begin
          w_op    = w_f7[5] ? OPWIDTH'(12) : OPWIDTH'(11);
          w_in2   = w_shamt;
          w_legal = w_f7 == 7'b0000000 || w_f7 == 7'b0100000;
        end
      endcase
    end else if (w_opc == 7'b0110011) begin
      w_in2   = r_regs[w_rs2];
      w_legal = w_f7 == 7'b0000000 ||
                (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
      case (w_f3)
        3'b000:  w_op = w_f7[5] ? OPWIDTH'(14) : OPWIDTH'(13);
        3'b001:  w_op = OPWIDTH'(15);
        3'b010:  w_op = OPWIDTH'(16);
        3'b011:  w_op = OPWIDTH'(17);
        3'b100:  w_op = OPWIDTH'(18);
        3'b101:  w_op = w_f7[5] ? OPWIDTH'(20) : OPWIDTH'(19);
        3'b110:  w_op = OPWIDTH'(21);
        default: w_op = OPWIDTH'(22);
      endcase
    end
    // Illegal words still walk EXEC/WB with a harmless ADD 0,0 on the ALU
    if (!w_legal) begin
      w_op  = OPWIDTH'(4);
      w_in1 = '0;
      w_in2 = '0;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_instr_valid ? EXEC : IDLE;
      EXEC:    w_next = WB;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_alu_in1     <= '0;
      o_alu_in2     <= '0;
      o_alu_op      <= OPWIDTH'(4);
      r_illegal     <= 1'b0;
      r_rd          <= '0;
      o_res_valid   <= 1'b0;
      o_res_illegal <= 1'b0;
      o_res_rd      <= '0;
      o_res_data    <= '0;
    end else begin
      o_res_valid <= 1'b0;
      if (w_accept) begin
        o_alu_in1 <= w_in1;
        o_alu_in2 <= w_in2;
        o_alu_op  <= w_op;
        r_illegal <= !w_legal;
        r_rd      <= i_instr[11:7];
      end
      if (r_state == WB) begin
        o_res_valid   <= 1'b1;
        o_res_illegal <= r_illegal;
        o_res_rd      <= r_rd;
        o_res_data    <= (r_illegal || r_rd == 5'd0) ? '0 : i_alu_result;
      end
    end
  end
  // x0 is never written, so reading entry 0 always yields zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_state == WB && !r_illegal && r_rd != 5'd0) begin
      r_regs[r_rd] <= i_alu_result;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors against alu_issue_stage with a behavioural ALU32 model on the return path
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] alu_in1, alu_in2, alu_result, res_data, dbg_data;
  logic [5:0]  alu_op;
  logic        res_valid, res_illegal;
  logic [4:0]  res_rd;
  logic [4:0]  dbg_addr = '0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mregs [32];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr(instr), .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .o_res_valid(res_valid), .o_res_illegal(res_illegal),
    .o_res_rd(res_rd), .o_res_data(res_data), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd4, 6'd13:  return a + b;
      6'd14:        return a - b;
      6'd5, 6'd16:  return {31'b0, $signed(a) < $signed(b)};
      6'd6, 6'd17:  return {31'b0, a < b};
      6'd7, 6'd18:  return a ^ b;
      6'd8, 6'd21:  return a | b;
      6'd9, 6'd22:  return a & b;
      6'd10, 6'd15: return a << b[4:0];
      6'd11, 6'd19: return a >> b[4:0];
      6'd12, 6'd20: return $unsigned($signed(a) >>> b[4:0]);
      default:      return '0;
    endcase
  endfunction
  assign alu_result = alu(alu_op, alu_in1, alu_in2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [5:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    wait_ready();
    instr_valid = 1'b1;
    instr = v.word;
    tick();
    instr_valid = 1'b0;
    instr = $urandom;
    chk("alu_op", {26'b0, alu_op}, {26'b0, v.op});
    chk("alu_in1", alu_in1, v.in1);
    chk("alu_in2", alu_in2, v.in2);
    chk("ready_exec", {31'b0, instr_ready}, 32'd0);
    tick();
    chk("valid_early", {31'b0, res_valid}, 32'd0);
    tick();
    chk("res_valid", {31'b0, res_valid}, 32'd1);
    chk("res_illegal", {31'b0, res_illegal}, {31'b0, v.ill});
    chk("res_rd", {27'b0, res_rd}, {27'b0, v.rd});
    chk("res_data", res_data, v.data);
    if (!v.ill && v.rd != 5'd0) mregs[v.rd] = v.data;
    dbg_addr = v.rd;
    #1;
    chk("dbg_rd", dbg_data, mregs[v.rd]);
  endtask

  vec_t vecs [13];
  int   accepts;
  int   pulses;
  logic [7:0] rdy_seen;

  initial begin
    vecs[0]  = '{32'hFFB00093, 6'd4,  32'h0,        32'hFFFFFFFB, 1'b0, 5'd1,  32'hFFFFFFFB};
    vecs[1]  = '{32'h00300113, 6'd4,  32'h0,        32'h3,        1'b0, 5'd2,  32'h3};
    vecs[2]  = '{32'h402081B3, 6'd14, 32'hFFFFFFFB, 32'h3,        1'b0, 5'd3,  32'hFFFFFFF8};
    vecs[3]  = '{32'h0020B233, 6'd17, 32'hFFFFFFFB, 32'h3,        1'b0, 5'd4,  32'h0};
    vecs[4]  = '{32'h4020D293, 6'd12, 32'hFFFFFFFB, 32'h2,        1'b0, 5'd5,  32'hFFFFFFFE};
    vecs[5]  = '{32'h0220D293, 6'd4,  32'h0,        32'h0,        1'b1, 5'd5,  32'h0};
    vecs[6]  = '{32'h00700013, 6'd4,  32'h0,        32'h7,        1'b0, 5'd0,  32'h0};
    vecs[7]  = '{32'h0000A383, 6'd4,  32'h0,        32'h0,        1'b1, 5'd7,  32'h0};
    vecs[8]  = '{32'h0020C3B3, 6'd18, 32'hFFFFFFFB, 32'h3,        1'b0, 5'd7,  32'hFFFFFFF8};
    vecs[9]  = '{32'h00411413, 6'd10, 32'h3,        32'h4,        1'b0, 5'd8,  32'h30};
    vecs[10] = '{32'h0F00F493, 6'd9,  32'hFFFFFFFB, 32'hF0,       1'b0, 5'd9,  32'hF0};
    vecs[11] = '{32'h0020A533, 6'd16, 32'hFFFFFFFB, 32'h3,        1'b0, 5'd10, 32'h1};
    vecs[12] = '{32'h4020E5B3, 6'd4,  32'h0,        32'h0,        1'b1, 5'd11, 32'h0};
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    #12;
    chk("rst_op", {26'b0, alu_op}, 32'd4);
    chk("rst_in1", alu_in1, 32'h0);
    chk("rst_in2", alu_in2, 32'h0);
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    dbg_addr = 5'd1;
    #1;
    chk("rst_x1", dbg_data, 32'h0);
    for (int i = 0; i < 13; i++) run_vec(vecs[i]);
    dbg_addr = 5'd0;
    #1;
    chk("x0_zero", dbg_data, 32'h0);
    // Back-to-back: valid held high for 8 cycles on ADDI x12,x12,1
    wait_ready();
    accepts = 0;
    pulses = 0;
    instr_valid = 1'b1;
    instr = 32'h00160613;
    for (int i = 0; i < 8; i++) begin
      rdy_seen[i] = instr_ready;
      if (instr_ready) accepts++;
      tick();
      if (res_valid) pulses++;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid) pulses++;
    end
    chk("ready_pattern", {24'b0, rdy_seen}, 32'h49);
    chk("accepts", accepts, 32'd3);
    chk("pulses", pulses, 32'd3);
    dbg_addr = 5'd12;
    #1;
    chk("x12_count", dbg_data, 32'd3);
    // Reset during EXEC of ADDI x6,x0,9 aborts it
    wait_ready();
    instr_valid = 1'b1;
    instr = 32'h00900313;
    tick();
    instr_valid = 1'b0;
    chk("abort_op_pre", {26'b0, alu_op}, 32'd4);
    chk("abort_in2_pre", alu_in2, 32'd9);
    rst_n = 1'b0;
    #2;
    chk("abort_op", {26'b0, alu_op}, 32'd4);
    chk("abort_in2", alu_in2, 32'd0);
    chk("abort_idle", {31'b0, instr_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (res_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 32'd0);
    dbg_addr = 5'd6;
    #1;
    chk("abort_x6", dbg_data, 32'h0);
    dbg_addr = 5'd1;
    #1;
    chk("abort_x1_cleared", dbg_data, 32'h0);
    run_vec('{32'h00900313, 6'd4, 32'h0, 32'h9, 1'b0, 5'd6, 32'h9});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
